interval_timer_ctrl: RTL

INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

---
 rtl/interval_timer_ctrl_if.sv | 21 ++
 rtl/interval_timer_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl_if.sv
// Handshake bundle between the light controller (master) and the interval timer (slave).
interface interval_timer_ctrl_if;
  logic       start_timer;
  logic [1:0] interval;
  logic       prog_sync;
  logic [1:0] prog_sel;
  logic [3:0] prog_val;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  modport master (
    output start_timer, interval, prog_sync, prog_sel, prog_val,
    input  expired, busy, remaining
  );

  modport slave (
    input  start_timer, interval, prog_sync, prog_sel, prog_val,
    output expired, busy, remaining
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Programmable seconds timer for the light controller: counts a selected interval in
// CLK_DIV-cycle ticks and pulses expired one cycle after the last tick.
module interval_timer_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  BASE_DEF = 4'd6,
  parameter logic [3:0]  EXT_DEF  = 4'd3,
  parameter logic [3:0]  YEL_DEF  = 4'd2
) (
  input  logic                   clk,
  input  logic                   g_reset,
  interval_timer_ctrl_if.slave   tif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_FIRE  = 2'd2
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [3:0] rem_q, rem_d;
  logic       pend_q, pend_d;
  logic [3:0] pend_len_q, pend_len_d;
  logic       start_q;
  logic [3:0] base_q, ext_q, yel_q;

  logic       start_req;
  logic       tick;
  logic [3:0] sel_len;
  logic [3:0] wr_val;

  assign start_req = tif.start_timer & ~start_q;
  assign tick      = (state_q == S_COUNT) && (tick_q == TICK_LAST);
  assign wr_val    = (tif.prog_val == 4'd0) ? 4'd1 : tif.prog_val;

  // Table registers are read before any same-cycle write lands.
  always_comb begin
    sel_len = 4'd0;
    case (tif.interval)
      2'b00:   sel_len = base_q;
      2'b01:   sel_len = ext_q;
      2'b10:   sel_len = yel_q;
      default: sel_len = 4'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    rem_d      = rem_q;
    pend_d     = 1'b0;
    pend_len_d = pend_len_q;
    case (state_q)
      S_IDLE: begin
        tick_d = 8'd0;
        if (pend_q) begin
          rem_d   = pend_len_q;
          state_d = (pend_len_q == 4'd0) ? S_FIRE : S_COUNT;
        end else if (start_req) begin
          rem_d   = sel_len;
          state_d = (sel_len == 4'd0) ? S_FIRE : S_COUNT;
        end
      end
      S_COUNT: begin
        if (start_req) begin
          // Restart abandons the running interval without an expiry.
          tick_d  = 8'd0;
          rem_d   = sel_len;
          state_d = (sel_len == 4'd0) ? S_FIRE : S_COUNT;
        end else if (tick) begin
          tick_d = 8'd0;
          if (rem_q <= 4'd1) begin
            rem_d   = 4'd0;
            state_d = S_FIRE;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      S_FIRE: begin
        tick_d  = 8'd0;
        state_d = S_IDLE;
        if (start_req) begin
          pend_d     = 1'b1;
          pend_len_d = sel_len;
        end
      end
      default: begin
        tick_d  = 8'd0;
        rem_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!g_reset) begin
      state_q    <= S_IDLE;
      tick_q     <= 8'd0;
      rem_q      <= 4'd0;
      pend_q     <= 1'b0;
      pend_len_q <= 4'd0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      rem_q      <= rem_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      start_q    <= tif.start_timer;
    end
  end

  always_ff @(posedge clk) begin
    if (!g_reset) begin
      base_q <= BASE_DEF;
      ext_q  <= EXT_DEF;
      yel_q  <= YEL_DEF;
    end else if (tif.prog_sync) begin
      case (tif.prog_sel)
        2'b00:   base_q <= wr_val;
        2'b01:   ext_q  <= wr_val;
        2'b10:   yel_q  <= wr_val;
        default: ;
      endcase
    end
  end

  assign tif.expired   = (state_q == S_FIRE);
  assign tif.busy      = (state_q == S_COUNT);
  assign tif.remaining = rem_q;

endmodule
